// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder: FSM states, ASCII command bytes,
// status LED bit positions and a hex-digit decoder.
package uart_cmd_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_PULSE_HI,
    ST_PULSE_LO,
    ST_DISCARD
  } state_t;

  localparam logic [7:0] CH_RST_LO = 8'h72;  // 'r'
  localparam logic [7:0] CH_RST_HI = 8'h52;  // 'R'
  localparam logic [7:0] CH_TM_LO  = 8'h74;  // 't'
  localparam logic [7:0] CH_TM_HI  = 8'h54;  // 'T'
  localparam logic [7:0] CH_CLR    = 8'h58;  // 'X'
  localparam logic [7:0] CH_LOAD   = 8'h4C;  // 'L'
  localparam logic [7:0] CH_CNT    = 8'h43;  // 'C'
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_ONE    = 8'h31;

  localparam int LED_RSTN = 0;
  localparam int LED_TM   = 1;
  localparam int LED_SE   = 2;
  localparam int LED_BUSY = 3;
  localparam int LED_ERR  = 4;
  localparam int LED_OVR  = 5;

  // Returns {valid, nibble}; letters map via low nibble + 9 ('A'/'a' -> 10).
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return {1'b1, 4'(c[3:0] + 4'd9)};
    return 5'b0;
  endfunction

  function automatic logic is_eol(input logic [7:0] c);
    return (c == CH_CR) || (c == CH_LF);
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// UART-side byte interface of the decoder: receive strobe/data in, echo start/data out.
// The decoder uses the slave modport; the UART wrapper (or bench) uses master.
interface uart_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic       tx_start_o;
  logic [7:0] tx_data_o;
  logic       tx_ready_i;

  modport master (output rx_data, output new_rx_data, output tx_ready_i,
                  input tx_start_o, input tx_data_o);
  modport slave  (input rx_data, input new_rx_data, input tx_ready_i,
                  output tx_start_o, output tx_data_o);
endinterface

// File: rtl/uart_cmd_decoder_csoc_clk_pulser.sv
// csoc_clk_pulser: one start strobe -> csoc_clk high for CLK_HALF cycles, then low for
// CLK_HALF cycles; fall_o/done_o mark the last cycle of each phase. Starts while active are ignored.
module csoc_clk_pulser #(
  parameter int CLK_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic csoc_clk_o,
  output logic fall_o,
  output logic done_o
);
  localparam logic [7:0] HALF_M1 = 8'(CLK_HALF - 1);

  logic       active_q, active_d;
  logic       clk_q, clk_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    active_d = active_q;
    clk_d    = clk_q;
    cnt_d    = cnt_q;
    if (start_i && !active_q) begin
      active_d = 1'b1;
      clk_d    = 1'b1;
      cnt_d    = HALF_M1;
    end else if (active_q) begin
      if (cnt_q == 8'd0) begin
        if (clk_q) begin
          clk_d = 1'b0;
          cnt_d = HALF_M1;
        end else begin
          active_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  // Async clear drops csoc_clk immediately, even mid-pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      clk_q    <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      active_q <= active_d;
      clk_q    <= clk_d;
      cnt_q    <= cnt_d;
    end
  end

  assign csoc_clk_o = clk_q;
  assign fall_o     = active_q && clk_q && (cnt_q == 8'd0);
  assign done_o     = active_q && !clk_q && (cnt_q == 8'd0);
endmodule

// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder driving CSoC clock/reset/scan pins from a UART byte stream.
// CMD_ECHO_EN adds a one-deep echo buffer toward the UART transmitter.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int CLK_HALF = 4,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_cmd_decoder_if.slave    uart,
  output logic                 csoc_clk_o,
  output logic                 csoc_rstn_o,
  output logic                 csoc_test_se_o,
  output logic                 csoc_test_tm_o,
  output logic [7:0]           csoc_data_o,
  output logic [7:0]           leds
);
  state_t             state_q, state_d;
  logic               rstn_q, rstn_d, tm_q, tm_d, se_q, se_d, data_q, data_d;
  logic               err_q, err_d, ovr_q, ovr_d, run_q, run_d, start_q, start_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy, accept, pulse_fall, pulse_done;
  logic [4:0]         hex;

  assign busy   = (state_q == ST_PULSE_HI) || (state_q == ST_PULSE_LO);
  assign accept = uart.new_rx_data && !busy;
  assign hex    = hex_decode(uart.rx_data);

  csoc_clk_pulser #(.CLK_HALF(CLK_HALF)) u_pulser (
    .clk(clk), .rst(rst), .start_i(start_q),
    .csoc_clk_o(csoc_clk_o), .fall_o(pulse_fall), .done_o(pulse_done)
  );

  always_comb begin
    state_d = state_q; rstn_d = rstn_q; tm_d = tm_q; se_d = se_q; data_d = data_q;
    err_d = err_q; ovr_d = ovr_q; run_d = run_q; count_d = count_q; start_d = 1'b0;
    if (uart.new_rx_data && busy) ovr_d = 1'b1;
    case (state_q)
      ST_IDLE: if (accept) begin
        case (uart.rx_data)
          CH_RST_LO: rstn_d = 1'b0;
          CH_RST_HI: rstn_d = 1'b1;
          CH_TM_LO:  tm_d = 1'b0;
          CH_TM_HI:  tm_d = 1'b1;
          CH_CLR:    begin err_d = 1'b0; ovr_d = 1'b0; end
          CH_LOAD:   state_d = ST_LOAD;
          CH_CNT:    begin count_d = '0; state_d = ST_CNT; end
          CH_SP, CH_CR, CH_LF: ;
          default:   begin err_d = 1'b1; state_d = ST_DISCARD; end
        endcase
      end
      ST_LOAD: if (accept) begin
        if (uart.rx_data == CH_ZERO || uart.rx_data == CH_ONE) begin
          data_d = uart.rx_data[0]; se_d = 1'b1; run_d = 1'b0;
          start_d = 1'b1; state_d = ST_PULSE_HI;
        end else if (is_eol(uart.rx_data)) begin
          se_d = 1'b0; state_d = ST_IDLE;
        end else begin
          err_d = 1'b1; se_d = 1'b0; state_d = ST_DISCARD;
        end
      end
      ST_CNT: if (accept) begin
        if (hex[4]) begin
          count_d = {count_q[CNT_W-5:0], hex[3:0]};
        end else if (is_eol(uart.rx_data)) begin
          if (count_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            run_d = 1'b1; se_d = 1'b0; start_d = 1'b1; state_d = ST_PULSE_HI;
          end
        end else begin
          err_d = 1'b1; state_d = ST_DISCARD;
        end
      end
      ST_PULSE_HI: if (pulse_fall) state_d = ST_PULSE_LO;
      // Run mode re-arms the pulser until the count drains; load mode returns to LOAD.
      ST_PULSE_LO: if (pulse_done) begin
        if (run_q) begin
          if (count_q != '0) count_d = count_q - CNT_W'(1);
          if (count_q <= CNT_W'(1)) begin
            run_d = 1'b0; state_d = ST_IDLE;
          end else begin
            start_d = 1'b1; state_d = ST_PULSE_HI;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DISCARD: if (accept && is_eol(uart.rx_data)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE; rstn_q <= 1'b0; tm_q <= 1'b0; se_q <= 1'b0; data_q <= 1'b0;
      err_q <= 1'b0; ovr_q <= 1'b0; run_q <= 1'b0; start_q <= 1'b0; count_q <= '0;
    end else begin
      state_q <= state_d; rstn_q <= rstn_d; tm_q <= tm_d; se_q <= se_d; data_q <= data_d;
      err_q <= err_d; ovr_q <= ovr_d; run_q <= run_d; start_q <= start_d; count_q <= count_d;
    end
  end

  assign csoc_rstn_o    = rstn_q;
  assign csoc_test_tm_o = tm_q;
  assign csoc_test_se_o = se_q;
  assign csoc_data_o    = {7'b0, data_q};

  always_comb begin
    leds           = '0;
    leds[LED_RSTN] = rstn_q;
    leds[LED_TM]   = tm_q;
    leds[LED_SE]   = se_q;
    leds[LED_BUSY] = busy;
    leds[LED_ERR]  = err_q;
    leds[LED_OVR]  = ovr_q;
  end

`ifdef CMD_ECHO_EN
  logic       buf_vld_q, buf_vld_d, tx_start_q, tx_start_d;
  logic [7:0] buf_dat_q, buf_dat_d, tx_data_q, tx_data_d;

  // A byte arriving while the buffer still holds one is decoded but not echoed.
  always_comb begin
    buf_vld_d  = buf_vld_q;
    buf_dat_d  = buf_dat_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    if (buf_vld_q && uart.tx_ready_i) begin
      tx_start_d = 1'b1;
      tx_data_d  = buf_dat_q;
      buf_vld_d  = 1'b0;
    end
    if (accept && !buf_vld_q) begin
      buf_vld_d = 1'b1;
      buf_dat_d = uart.rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld_q <= 1'b0; buf_dat_q <= 8'h00; tx_start_q <= 1'b0; tx_data_q <= 8'h00;
    end else begin
      buf_vld_q <= buf_vld_d; buf_dat_q <= buf_dat_d; tx_start_q <= tx_start_d; tx_data_q <= tx_data_d;
    end
  end

  assign uart.tx_start_o = tx_start_q;
  assign uart.tx_data_o  = tx_data_q;
`else
  logic unused_tx_ready;
  assign unused_tx_ready = uart.tx_ready_i;
  assign uart.tx_start_o = 1'b0;
  assign uart.tx_data_o  = 8'h00;
`endif
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized and directed bench for uart_cmd_decoder with a byte-level reference model
// of the command language; observed csoc_clk pulses and echoes are scoreboarded.
module tb_uart_cmd_decoder;
  localparam int H = 2;
  localparam int M_IDLE = 0, M_LOAD = 1, M_CNT = 2, M_DISC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       csoc_clk_o, csoc_rstn_o, csoc_test_se_o, csoc_test_tm_o;
  logic [7:0] csoc_data_o, leds;

  uart_cmd_decoder_if u_if();

  uart_cmd_decoder #(.CLK_HALF(H), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .uart(u_if),
    .csoc_clk_o(csoc_clk_o), .csoc_rstn_o(csoc_rstn_o),
    .csoc_test_se_o(csoc_test_se_o), .csoc_test_tm_o(csoc_test_tm_o),
    .csoc_data_o(csoc_data_o), .leds(leds)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int        m_mode, m_cnt;
  bit        m_rstn, m_tm, m_se, m_err, m_ovr, m_busy, m_data;
  bit [1:0]  exp_q[$];
  byte       echo_exp[$];

  // Observations
  bit [1:0]  obs_q[$];
  int        hi_w_q[$], lo_w_q[$];
  byte       echo_obs[$];
  int        n_rise = 0;
  bit        prev_clk = 1'b0, lo_on = 1'b0;
  int        hi_cnt = 0, lo_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_clk = 1'b0; lo_on = 1'b0; hi_cnt = 0; lo_cnt = 0;
    end else begin
      if (lo_on && (csoc_clk_o || !leds[3])) begin
        lo_w_q.push_back(lo_cnt); lo_on = 1'b0; lo_cnt = 0;
      end
      if (csoc_clk_o && !prev_clk) begin
        obs_q.push_back({csoc_data_o[0], csoc_test_se_o});
        n_rise++;
      end
      if (!csoc_clk_o && prev_clk) begin
        hi_w_q.push_back(hi_cnt); hi_cnt = 0; lo_on = 1'b1;
      end
      if (csoc_clk_o) hi_cnt++;
      if (lo_on && !csoc_clk_o) lo_cnt++;
      prev_clk = csoc_clk_o;
      if (u_if.tx_start_o) echo_obs.push_back(u_if.tx_data_o);
    end
  end

  task automatic m_reset();
    m_mode = M_IDLE; m_cnt = 0; m_rstn = 0; m_tm = 0; m_se = 0;
    m_err = 0; m_ovr = 0; m_busy = 0; m_data = 0;
  endtask

  function automatic int hexval(input byte b);
    if (b >= "0" && b <= "9") return b - "0";
    if (b >= "a" && b <= "f") return b - "a" + 10;
    if (b >= "A" && b <= "F") return b - "A" + 10;
    return -1;
  endfunction

  function automatic bit is_eol(input byte b);
    return (b == 8'h0A) || (b == 8'h0D);
  endfunction

  task automatic m_byte(input byte b, input bit dropped);
    int hv;
    if (dropped) begin m_ovr = 1; return; end
`ifdef CMD_ECHO_EN
    echo_exp.push_back(b);
`endif
    hv = hexval(b);
    case (m_mode)
      M_IDLE: begin
        if (b == "r") m_rstn = 0;
        else if (b == "R") m_rstn = 1;
        else if (b == "t") m_tm = 0;
        else if (b == "T") m_tm = 1;
        else if (b == "X") begin m_err = 0; m_ovr = 0; end
        else if (b == "L") m_mode = M_LOAD;
        else if (b == "C") begin m_cnt = 0; m_mode = M_CNT; end
        else if (b == " " || is_eol(b)) ;
        else begin m_err = 1; m_mode = M_DISC; end
      end
      M_LOAD: begin
        if (b == "0" || b == "1") begin
          m_data = (b == "1"); m_se = 1; exp_q.push_back({m_data, 1'b1}); m_busy = 1;
        end else if (is_eol(b)) begin
          m_se = 0; m_mode = M_IDLE;
        end else begin
          m_err = 1; m_se = 0; m_mode = M_DISC;
        end
      end
      M_CNT: begin
        if (hv >= 0) m_cnt = (m_cnt * 16 + hv) % 65536;
        else if (is_eol(b)) begin
          for (int i = 0; i < m_cnt; i++) exp_q.push_back({m_data, 1'b0});
          if (m_cnt > 0) m_busy = 1;
          m_cnt = 0; m_mode = M_IDLE;
        end else begin
          m_err = 1; m_mode = M_DISC;
        end
      end
      default: if (is_eol(b)) m_mode = M_IDLE;
    endcase
  endtask

  task automatic wait_not_busy();
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (leds[3] === 1'b0) break;
    end
    if (i == 5000) check("busy_timeout", leds[3], 0);
  endtask

  task automatic send(input byte b, input bit wait_idle);
    bit dropped;
    if (wait_idle) begin
      wait_not_busy(); m_busy = 0;
      @(posedge clk); #1;
    end
    dropped = m_busy;
    m_byte(b, dropped);
    u_if.rx_data = b; u_if.new_rx_data = 1'b1;
    @(posedge clk); #1;
    u_if.new_rx_data = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b1);
  endtask

  task automatic checkpoint(input string tag);
    int n;
    wait_not_busy();
    repeat (3) @(negedge clk);
    check({tag, ":leds"}, leds, {2'b0, m_ovr, m_err, 1'b0, m_se, m_tm, m_rstn});
    check({tag, ":pins"}, {csoc_rstn_o, csoc_test_tm_o, csoc_test_se_o, csoc_clk_o},
          {m_rstn, m_tm, m_se, 1'b0});
    check({tag, ":npulse"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, ":pulse_data_se"}, obs_q[i], exp_q[i]);
    check({tag, ":necho"}, echo_obs.size(), echo_exp.size());
    n = (echo_obs.size() < echo_exp.size()) ? echo_obs.size() : echo_exp.size();
    for (int i = 0; i < n; i++) check({tag, ":echo"}, echo_obs[i], echo_exp[i]);
    obs_q.delete(); exp_q.delete(); echo_obs.delete(); echo_exp.delete();
    hi_w_q.delete(); lo_w_q.delete();
  endtask

  function automatic byte rnd_eol();
    return ($urandom_range(0, 1) != 0) ? 8'h0A : 8'h0D;
  endfunction

  function automatic byte hexch(input int v);
    if (v < 10) return byte'(8'h30 + v);
    return byte'((($urandom_range(0, 1) != 0) ? 8'h61 : 8'h41) + v - 10);
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r0, i;
    string cmds, junk;
    cmds = "rRtT";
    junk = "Qz#9!";
    u_if.rx_data = 8'h00; u_if.new_rx_data = 1'b0; u_if.tx_ready_i = 1'b1;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pins", {csoc_clk_o, csoc_rstn_o, csoc_test_se_o, csoc_test_tm_o}, 4'h0);
    check("rst_data", csoc_data_o, 8'h00);
    check("rst_leds", leds, 8'h00);
    check("rst_tx", {u_if.tx_start_o, u_if.tx_data_o}, 9'h000);
    @(posedge clk); #1 rst = 1'b0;

    send_str("RT");
    checkpoint("rt");
    check("leds_RT", leds, 8'h03);

    send_str("L101\n");
    wait_not_busy();
    repeat (2) @(negedge clk);
    check("load_hi_count", hi_w_q.size(), 3);
    check("load_lo_count", lo_w_q.size(), 3);
    foreach (hi_w_q[k]) check("load_hi_width", hi_w_q[k], H);
    foreach (lo_w_q[k]) check("load_lo_width", lo_w_q[k], H);
    checkpoint("load101");

    r0 = n_rise;
    send_str("C1a\n");
    checkpoint("c1a");
    check("c1a_pulses", n_rise - r0, 26);
    send_str("C0\n");
    checkpoint("c0");
    send_str("C1000a\n");
    checkpoint("c_trunc");

    send_str("Q");
    send_str("L1\n");
    checkpoint("bad_cmd");
    send_str("t");
    checkpoint("after_err");
    send_str("X");
    checkpoint("clr");
    check("err_cleared", leds[4], 0);

    send_str("L1");
    send("0", 1'b0);
    send_str("\n");
    checkpoint("overrun");
    check("ovr_flag", leds[5], 1);
    send_str("X");
    checkpoint("clr2");

    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 6))
        0: begin
          send("L", 1);
          repeat ($urandom_range(1, 4)) send(($urandom_range(0, 1) != 0) ? "1" : "0", 1);
          send(rnd_eol(), 1);
        end
        1: begin
          int nd;
          nd = $urandom_range(0, 2);
          send("C", 1);
          for (int j = 0; j < nd; j++)
            send(hexch((j == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15)), 1);
          send(rnd_eol(), 1);
        end
        2: send(cmds[$urandom_range(0, 3)], 1);
        3: begin
          send(junk[$urandom_range(0, 4)], 1);
          send("L", 1); send("1", 1); send(rnd_eol(), 1);
        end
        4: send(" ", 1);
        5: begin send("L", 1); send("1", 1); send("7", 1); send(rnd_eol(), 1); end
        default: send("X", 1);
      endcase
      checkpoint("rnd");
    end

    send_str("TR");
    checkpoint("echo_tr");

    send_str("C5");
    checkpoint("c5_setup");
    r0 = n_rise;
    send(8'h0A, 1);
    for (i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (n_rise - r0 >= 3) break;
    end
    if (i == 300) check("third_pulse_timeout", n_rise - r0, 3);
    check("clk_hi_before_rst", csoc_clk_o, 1);
    rst = 1'b1;
    #1 check("rst_async_clk", csoc_clk_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
    repeat (100) @(negedge clk);
    check("no_resume", n_rise - r0, 3);
    check("post_rst_leds", leds, 8'h00);
    obs_q.delete(); exp_q.delete(); echo_obs.delete(); echo_exp.delete();

`ifndef CMD_ECHO_EN
    check("tx_idle", {u_if.tx_start_o, u_if.tx_data_o}, 9'h000);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
